i2c_reg_seq: RTL
================

I2C_REG_SEQ -- requirements
Module: i2c_reg_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: master clock, all state on its rising edge.
REQ-002 SHALL have port nReset, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-004 SHALL have port req, input, 1 bit: transaction request, sampled only in IDLE.
REQ-005 SHALL have port rnw, input, 1 bit: 1 = register read, 0 = register write.
REQ-006 SHALL have port dev_addr, input, 7 bits: slave address.
REQ-007 SHALL have port reg_addr, input, 8 bits: register index.
REQ-008 SHALL have port wdata, input, 8 bits: write data.
REQ-009 SHALL have port busy, output, 1 bit: transaction in progress.
REQ-010 SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-011 SHALL have port rdata, output, 8 bits: read result.
REQ-012 SHALL have port err, output, 2 bits: 00 ok, 01 slave NACK, 10 arbitration lost.
REQ-013 SHALL have outputs bc_start, bc_stop, bc_read, bc_write and bc_ack_in (1 bit each), and bc_din (8 bits), as byte-controller command outputs.
REQ-014 SHALL have inputs bc_cmd_ack, bc_ack_out and bc_al (1 bit each), and bc_dout (8 bits), as byte-controller status inputs.

Function
REQ-015 SHALL implement states IDLE, DEVW, REGA, WDAT, DEVR, RDAT, ABORT, DONE; all outputs registered.
REQ-016 SHALL, in IDLE with req=1 at edge k, latch rnw/dev_addr/reg_addr/wdata, enter DEVW and drive busy=1, bc_start=bc_write=1, bc_din={dev_addr,0} from cycle k+1.
REQ-017 SHALL hold every bc_* command output stable until the edge on which bc_cmd_ack=1, then load the next command (or clear all) on that same edge.
REQ-018 SHALL, on DEVW ack with bc_ack_out=0, enter REGA with bc_write=1, bc_din=reg_addr.
REQ-019 SHALL, on REGA ack with bc_ack_out=0, enter WDAT (rnw=0: bc_write=bc_stop=1, bc_din=wdata) or DEVR (rnw=1: bc_start=bc_write=1, bc_din={dev_addr,1}).
REQ-020 SHALL, on DEVR ack with bc_ack_out=0, enter RDAT with bc_read=bc_stop=1, bc_ack_in=1 (master NACK).
REQ-021 SHALL, on RDAT ack, capture rdata<=bc_dout and enter DONE with err=00.
REQ-022 SHALL, on WDAT ack, enter DONE with err=00 if bc_ack_out=0, else err=01; no extra stop issued.
REQ-023 SHALL, on ack with bc_ack_out=1 in DEVW, REGA or DEVR, enter ABORT issuing bc_stop=1 only, then DONE with err=01 on its ack.
REQ-024 SHALL, on bc_al=1 in any non-IDLE state, clear all bc_* commands on the same edge and enter DONE with err=10; no stop issued.
REQ-025 SHALL, in DONE, assert done=1 for exactly one cycle with busy=0 in that cycle, then return to IDLE.
REQ-026 SHALL ignore req while busy=1 and while in DONE; a req held high is re-accepted on the first IDLE cycle after DONE.
REQ-027 SHALL hold err and rdata until the next accepted request; rdata SHALL be unchanged by write transactions and aborts.
REQ-028 SHALL treat bc_al with priority over a simultaneous bc_cmd_ack.
REQ-029 SHALL drive bc_ack_in=0 except during RDAT.

Reset
REQ-030 SHALL, on nReset=0 (async) or rst=1 (sync, also mid-transaction), force IDLE, busy=0, done=0, rdata=00h, err=00, and all bc_* outputs 0; no done pulse SHALL result.

Verification
REQ-031 Write dev=50h reg=10h wdata=A5h, all slave ACK -> bc_din sequence A0h,10h,A5h; stop only with third; done, err=00.
REQ-032 Read dev=50h reg=10h, slave returns 3Ch -> A0h, 10h, start+A1h, read+stop with bc_ack_in=1; rdata=3Ch, err=00.
REQ-033 Write with NACK on address byte A0h -> next command stop-only, exactly 2 commands total; done, err=01.
REQ-034 bc_al pulse during REGA -> commands cleared next edge, no stop; done, err=10; rdata retains prior value.
REQ-035 rst asserted in DEVR -> all outputs at reset values next cycle, no done; new req then runs normally.
REQ-036 req pulsed during busy -> ignored; req held continuously -> back-to-back transactions with one IDLE cycle between.

Source files
------------

// File: rtl/i2c_reg_seq_if.sv
// Signal bundle between the register sequencer, its requester and the I2C byte controller.
// The master modport is the sequencer's view; slave is the view of the logic around it.
interface i2c_reg_seq_if;
    logic       req;
    logic       rnw;
    logic [6:0] dev_addr;
    logic [7:0] reg_addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic [1:0] err;
    logic       bc_start;
    logic       bc_stop;
    logic       bc_read;
    logic       bc_write;
    logic       bc_ack_in;
    logic [7:0] bc_din;
    logic       bc_cmd_ack;
    logic       bc_ack_out;
    logic       bc_al;
    logic [7:0] bc_dout;

    modport master (
        input  req, rnw, dev_addr, reg_addr, wdata,
        input  bc_cmd_ack, bc_ack_out, bc_al, bc_dout,
        output busy, done, rdata, err,
        output bc_start, bc_stop, bc_read, bc_write, bc_ack_in, bc_din
    );

    modport slave (
        output req, rnw, dev_addr, reg_addr, wdata,
        output bc_cmd_ack, bc_ack_out, bc_al, bc_dout,
        input  busy, done, rdata, err,
        input  bc_start, bc_stop, bc_read, bc_write, bc_ack_in, bc_din
    );
endinterface

// File: rtl/i2c_reg_seq.sv
// Single-register I2C read/write sequencer driving a byte-level I2C controller.
// Every output, including the byte-controller command word, comes straight from a flop.
module i2c_reg_seq (
    input  logic          clk,
    input  logic          nReset,
    input  logic          rst,
    i2c_reg_seq_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DEVW  = 3'd1,
        ST_REGA  = 3'd2,
        ST_WDAT  = 3'd3,
        ST_DEVR  = 3'd4,
        ST_RDAT  = 3'd5,
        ST_ABORT = 3'd6,
        ST_DONE  = 3'd7
    } state_t;

    typedef struct packed {
        logic       start;
        logic       stop;
        logic       read;
        logic       write;
        logic       ack_in;
        logic [7:0] din;
    } cmd_t;

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_NACK = 2'b01;
    localparam logic [1:0] ERR_AL   = 2'b10;

    function automatic cmd_t mk_cmd(input logic s, input logic p, input logic r,
                                    input logic w, input logic a, input logic [7:0] d);
        cmd_t c;
        c.start  = s;
        c.stop   = p;
        c.read   = r;
        c.write  = w;
        c.ack_in = a;
        c.din    = d;
        return c;
    endfunction

    localparam cmd_t CMD_NONE = '{start: 1'b0, stop: 1'b0, read: 1'b0, write: 1'b0,
                                  ack_in: 1'b0, din: 8'h00};

    state_t     state_r, state_s;
    logic       rnw_r, rnw_s;
    logic [6:0] dev_r, dev_s;
    logic [7:0] reg_r, reg_s;
    logic [7:0] wdata_r, wdata_s;
    logic       busy_r, busy_s;
    logic       done_r, done_s;
    logic [7:0] rdata_r, rdata_s;
    logic [1:0] err_r, err_s;
    cmd_t       cmd_r, cmd_s;

    // Next-state and next-output decode; commands hold until the byte controller acknowledges.
    always_comb begin
        state_s = state_r;
        rnw_s   = rnw_r;
        dev_s   = dev_r;
        reg_s   = reg_r;
        wdata_s = wdata_r;
        busy_s  = busy_r;
        done_s  = 1'b0;
        rdata_s = rdata_r;
        err_s   = err_r;
        cmd_s   = cmd_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.req) begin
                    rnw_s   = bus.rnw;
                    dev_s   = bus.dev_addr;
                    reg_s   = bus.reg_addr;
                    wdata_s = bus.wdata;
                    busy_s  = 1'b1;
                    state_s = ST_DEVW;
                    cmd_s   = mk_cmd(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, {bus.dev_addr, 1'b0});
                end else begin
                    busy_s  = 1'b0;
                    cmd_s   = CMD_NONE;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
                cmd_s   = CMD_NONE;
            end
            ST_DEVW, ST_REGA, ST_WDAT, ST_DEVR, ST_RDAT, ST_ABORT: begin
                // Arbitration loss wins over any acknowledge arriving in the same cycle.
                if (bus.bc_al) begin
                    state_s = ST_DONE;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    err_s   = ERR_AL;
                    cmd_s   = CMD_NONE;
                end else if (bus.bc_cmd_ack) begin
                    case (state_r)
                        ST_DEVW: begin
                            if (bus.bc_ack_out) begin
                                state_s = ST_ABORT;
                                cmd_s   = mk_cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
                            end else begin
                                state_s = ST_REGA;
                                cmd_s   = mk_cmd(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, reg_r);
                            end
                        end
                        ST_REGA: begin
                            if (bus.bc_ack_out) begin
                                state_s = ST_ABORT;
                                cmd_s   = mk_cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
                            end else if (rnw_r) begin
                                state_s = ST_DEVR;
                                cmd_s   = mk_cmd(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, {dev_r, 1'b1});
                            end else begin
                                state_s = ST_WDAT;
                                cmd_s   = mk_cmd(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, wdata_r);
                            end
                        end
                        ST_DEVR: begin
                            if (bus.bc_ack_out) begin
                                state_s = ST_ABORT;
                                cmd_s   = mk_cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
                            end else begin
                                // Single-byte read: master NACKs the byte, stop rides along.
                                state_s = ST_RDAT;
                                cmd_s   = mk_cmd(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
                            end
                        end
                        ST_WDAT: begin
                            state_s = ST_DONE;
                            busy_s  = 1'b0;
                            done_s  = 1'b1;
                            err_s   = bus.bc_ack_out ? ERR_NACK : ERR_OK;
                            cmd_s   = CMD_NONE;
                        end
                        ST_RDAT: begin
                            state_s = ST_DONE;
                            busy_s  = 1'b0;
                            done_s  = 1'b1;
                            err_s   = ERR_OK;
                            rdata_s = bus.bc_dout;
                            cmd_s   = CMD_NONE;
                        end
                        ST_ABORT: begin
                            state_s = ST_DONE;
                            busy_s  = 1'b0;
                            done_s  = 1'b1;
                            err_s   = ERR_NACK;
                            cmd_s   = CMD_NONE;
                        end
                        default: begin
                            state_s = ST_IDLE;
                            busy_s  = 1'b0;
                            cmd_s   = CMD_NONE;
                        end
                    endcase
                end else begin
                    cmd_s = cmd_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
                cmd_s   = CMD_NONE;
            end
        endcase
    end

    // State and output registers; the synchronous reset also aborts a running transaction.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_r <= ST_IDLE;
            rnw_r   <= 1'b0;
            dev_r   <= 7'h00;
            reg_r   <= 8'h00;
            wdata_r <= 8'h00;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            rdata_r <= 8'h00;
            err_r   <= 2'b00;
            cmd_r   <= CMD_NONE;
        end else if (rst) begin
            state_r <= ST_IDLE;
            rnw_r   <= 1'b0;
            dev_r   <= 7'h00;
            reg_r   <= 8'h00;
            wdata_r <= 8'h00;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            rdata_r <= 8'h00;
            err_r   <= 2'b00;
            cmd_r   <= CMD_NONE;
        end else begin
            state_r <= state_s;
            rnw_r   <= rnw_s;
            dev_r   <= dev_s;
            reg_r   <= reg_s;
            wdata_r <= wdata_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            rdata_r <= rdata_s;
            err_r   <= err_s;
            cmd_r   <= cmd_s;
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.rdata     = rdata_r;
    assign bus.err       = err_r;
    assign bus.bc_start  = cmd_r.start;
    assign bus.bc_stop   = cmd_r.stop;
    assign bus.bc_read   = cmd_r.read;
    assign bus.bc_write  = cmd_r.write;
    assign bus.bc_ack_in = cmd_r.ack_in;
    assign bus.bc_din    = cmd_r.din;

endmodule
